// File: rtl/lc3_mmio.sv
// LC-3 device-register responder: keyboard (KBSR/KBDR), display (DSR/DDR) and MCR run bit.
// Define LC3_MMIO_INTR_EN to make KBSR[14]/DSR[14] live and drive kb_irq/dsp_irq.
module lc3_mmio (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    input  logic        we,
    input  logic        re,
    output logic [15:0] rdata,
    output logic        hit,
    input  logic        kb_valid,
    input  logic [7:0]  kb_data,
    output logic        kb_ready,
    output logic        dsp_valid,
    output logic [7:0]  dsp_data,
    input  logic        dsp_ready,
    output logic        mcr_run,
    output logic        kb_irq,
    output logic        dsp_irq
);

    localparam logic [15:0] KBSR_A = 16'hFE00;
    localparam logic [15:0] KBDR_A = 16'hFE02;
    localparam logic [15:0] DSR_A  = 16'hFE04;
    localparam logic [15:0] DDR_A  = 16'hFE06;
    localparam logic [15:0] MCR_A  = 16'hFFFE;

    logic       kb_full;
    logic [7:0] kbdr;
    logic       dsr_rdy;
    logic [7:0] ddr;
    logic       mcr_q;
    logic       kb_ie;
    logic       dsp_ie;

    logic kb_accept;
    logic kbdr_load;
    logic ddr_store;
    logic dsp_accept;

    assign kb_ready   = ~kb_full;
    assign kb_accept  = kb_valid & ~kb_full;
    assign kbdr_load  = re & (addr == KBDR_A);
    assign ddr_store  = we & (addr == DDR_A) & dsr_rdy;
    assign dsp_valid  = ~dsr_rdy;
    assign dsp_accept = ~dsr_rdy & dsp_ready;
    assign dsp_data   = ddr;
    assign mcr_run    = mcr_q;

    // Keyboard: an incoming byte sets ready, a KBDR load clears it; set wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            kb_full <= 1'b0;
            kbdr    <= 8'h00;
        end else begin
            if (kb_accept) begin
                kb_full <= 1'b1;
                kbdr    <= kb_data;
            end else if (kbdr_load) begin
                kb_full <= 1'b0;
            end
        end
    end

    // Display: a store only lands while ready; the sink's accept reopens it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dsr_rdy <= 1'b1;
            ddr     <= 8'h00;
        end else begin
            if (ddr_store) begin
                dsr_rdy <= 1'b0;
                ddr     <= wdata[7:0];
            end else if (dsp_accept) begin
                dsr_rdy <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcr_q <= 1'b1;
        end else if (we && addr == MCR_A) begin
            mcr_q <= wdata[15];
        end
    end

`ifdef LC3_MMIO_INTR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            kb_ie  <= 1'b0;
            dsp_ie <= 1'b0;
        end else begin
            if (we && addr == KBSR_A) kb_ie  <= wdata[14];
            if (we && addr == DSR_A)  dsp_ie <= wdata[14];
        end
    end

    assign kb_irq  = kb_full & kb_ie;
    assign dsp_irq = dsr_rdy & dsp_ie;

    logic unused_wdata;
    assign unused_wdata = ^wdata[13:8];
`else
    assign kb_ie   = 1'b0;
    assign dsp_ie  = 1'b0;
    assign kb_irq  = 1'b0;
    assign dsp_irq = 1'b0;

    logic unused_wdata;
    assign unused_wdata = ^wdata[14:8];
`endif

    always_comb begin
        rdata = 16'h0000;
        hit   = 1'b1;
        case (addr)
            KBSR_A:  rdata = {kb_full, kb_ie, 14'h0000};
            KBDR_A:  rdata = {8'h00, kbdr};
            DSR_A:   rdata = {dsr_rdy, dsp_ie, 14'h0000};
            DDR_A:   rdata = {8'h00, ddr};
            MCR_A:   rdata = {mcr_q, 15'h0000};
            default: hit   = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_lc3_mmio.sv
// Directed bench for lc3_mmio: reset state, register map, keyboard/display handshakes, MCR, interrupt bits.
module tb_lc3_mmio;

    logic        clk;
    logic        reset;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        we;
    logic        re;
    logic [15:0] rdata;
    logic        hit;
    logic        kb_valid;
    logic [7:0]  kb_data;
    logic        kb_ready;
    logic        dsp_valid;
    logic [7:0]  dsp_data;
    logic        dsp_ready;
    logic        mcr_run;
    logic        kb_irq;
    logic        dsp_irq;

    int checks   = 0;
    int failures = 0;

    lc3_mmio dut (
        .clk       (clk),
        .reset     (reset),
        .addr      (addr),
        .wdata     (wdata),
        .we        (we),
        .re        (re),
        .rdata     (rdata),
        .hit       (hit),
        .kb_valid  (kb_valid),
        .kb_data   (kb_data),
        .kb_ready  (kb_ready),
        .dsp_valid (dsp_valid),
        .dsp_data  (dsp_data),
        .dsp_ready (dsp_ready),
        .mcr_run   (mcr_run),
        .kb_irq    (kb_irq),
        .dsp_irq   (dsp_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are changed 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Put an address on the bus and let the combinational read settle.
    task automatic look(input logic [15:0] a);
        addr = a;
        #1;
    endtask

    task automatic store(input logic [15:0] a, input logic [15:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        tick();
        we    = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b1; addr = 16'h0000; wdata = 16'h0000; we = 1'b0; re = 1'b0;
        kb_valid = 1'b0; kb_data = 8'h00; dsp_ready = 1'b0;
        #2;
        check("rst_kb_ready", 16'(kb_ready), 16'h1);
        check("rst_dsp_valid", 16'(dsp_valid), 16'h0);
        check("rst_dsp_data", 16'(dsp_data), 16'h00);
        check("rst_mcr_run", 16'(mcr_run), 16'h1);
        check("rst_kb_irq", 16'(kb_irq), 16'h0);
        check("rst_dsp_irq", 16'(dsp_irq), 16'h0);
        tick();
        reset = 1'b0;

        // Register map after reset
        re = 1'b1;
        look(16'hFE04); check("dsr_rst", rdata, 16'h8000); check("dsr_hit", 16'(hit), 16'h1);
        look(16'hFFFE); check("mcr_rst", rdata, 16'h8000); check("mcr_hit", 16'(hit), 16'h1);
        look(16'h3000); check("miss_rdata", rdata, 16'h0000); check("miss_hit", 16'(hit), 16'h0);
        look(16'hFE00); check("kbsr_rst", rdata, 16'h0000);
        look(16'hFE06); check("ddr_rst", rdata, 16'h0000);
        look(16'hFE02); check("kbdr_rst", rdata, 16'h0000);
        re = 1'b0;
        look(16'hFE00);

        // Keyboard byte x41, then load KBDR
        kb_valid = 1'b1; kb_data = 8'h41; #1;
        check("kb_ready_empty", 16'(kb_ready), 16'h1);
        tick();
        kb_valid = 1'b0;
        look(16'hFE00); check("kbsr_full", rdata, 16'h8000);
        check("kb_ready_full", 16'(kb_ready), 16'h0);
        re = 1'b1;
        look(16'hFE02); check("kbdr_41", rdata, 16'h0041);
        tick();
        re = 1'b0;
        look(16'hFE00); check("kbsr_cleared", rdata, 16'h0000);
        check("kb_ready_again", 16'(kb_ready), 16'h1);

        // Load while full with a new byte offered: clear wins, byte waits a cycle
        kb_valid = 1'b1; kb_data = 8'h55;
        tick();
        kb_data = 8'h66; re = 1'b1;
        look(16'hFE02);
        check("full_ld_ready", 16'(kb_ready), 16'h0);
        check("full_ld_rdata", rdata, 16'h0055);
        tick();
        re = 1'b0;
        look(16'hFE00); check("full_ld_kbsr", rdata, 16'h0000);
        check("full_ld_ready2", 16'(kb_ready), 16'h1);
        tick();
        kb_valid = 1'b0;
        look(16'hFE00); check("full_ld_kbsr2", rdata, 16'h8000);
        look(16'hFE02); check("full_ld_kbdr", rdata, 16'h0066);

        // Load while empty with a byte offered: set wins, old data returned
        re = 1'b1;
        tick();
        kb_valid = 1'b1; kb_data = 8'h77;
        look(16'hFE02); check("empty_ld_rdata", rdata, 16'h0066);
        tick();
        re = 1'b0; kb_valid = 1'b0;
        look(16'hFE00); check("empty_ld_kbsr", rdata, 16'h8000);
        look(16'hFE02); check("empty_ld_kbdr", rdata, 16'h0077);
        re = 1'b1;
        tick();
        re = 1'b0;
        store(16'hFE02, 16'h1234);
        look(16'hFE02); check("kbdr_store_ignored", rdata, 16'h0077);

        // Display store with the sink stalled
        dsp_ready = 1'b0;
        store(16'hFE06, 16'h0048);
        look(16'hFE04);
        check("dsp_valid_c1", 16'(dsp_valid), 16'h1);
        check("dsp_data_c1", 16'(dsp_data), 16'h48);
        check("dsr_busy_c1", rdata, 16'h0000);
        store(16'hFE06, 16'h0049);
        look(16'hFE04);
        check("dsp_valid_c2", 16'(dsp_valid), 16'h1);
        check("dsp_data_c2", 16'(dsp_data), 16'h48);
        check("dsr_busy_c2", rdata, 16'h0000);
        tick();
        check("dsp_valid_c3", 16'(dsp_valid), 16'h1);
        check("dsr_busy_c3", rdata, 16'h0000);
        look(16'hFE06); check("ddr_drop", rdata, 16'h0048);
        dsp_ready = 1'b1;
        tick();
        dsp_ready = 1'b0;
        look(16'hFE04); check("dsr_ready_back", rdata, 16'h8000);
        check("dsp_valid_drop", 16'(dsp_valid), 16'h0);

        // MCR writes only bit 15
        store(16'hFFFE, 16'h7FFF);
        look(16'hFFFE); check("mcr_low_bits", rdata, 16'h0000);
        check("mcr_run_0", 16'(mcr_run), 16'h0);

        // Asynchronous reset in the middle of a display handshake
        store(16'hFE06, 16'h0050);
        check("dsp_valid_pre_rst", 16'(dsp_valid), 16'h1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_dsp_valid", 16'(dsp_valid), 16'h0);
        check("arst_mcr_run", 16'(mcr_run), 16'h1);
        check("arst_dsp_data", 16'(dsp_data), 16'h00);
        look(16'hFE04); check("arst_dsr", rdata, 16'h8000);
        tick();
        reset = 1'b0;

        // Interrupt enable bits
        store(16'hFE00, 16'h4000);
        kb_valid = 1'b1; kb_data = 8'h0D;
        tick();
        kb_valid = 1'b0;
        look(16'hFE00);
`ifdef LC3_MMIO_INTR_EN
        check("irq_kbsr", rdata, 16'hC000);
        check("irq_kb_on", 16'(kb_irq), 16'h1);
`else
        check("irq_kbsr", rdata, 16'h8000);
        check("irq_kb_on", 16'(kb_irq), 16'h0);
`endif
        re = 1'b1;
        look(16'hFE02); check("irq_kbdr", rdata, 16'h000D);
        tick();
        re = 1'b0;
        look(16'hFE00);
        check("irq_kb_off", 16'(kb_irq), 16'h0);
`ifdef LC3_MMIO_INTR_EN
        check("irq_kbsr_ie", rdata, 16'h4000);
`else
        check("irq_kbsr_ie", rdata, 16'h0000);
`endif
        store(16'hFE04, 16'h4000);
        look(16'hFE04);
`ifdef LC3_MMIO_INTR_EN
        check("irq_dsr", rdata, 16'hC000);
        check("irq_dsp", 16'(dsp_irq), 16'h1);
`else
        check("irq_dsr", rdata, 16'h8000);
        check("irq_dsp", 16'(dsp_irq), 16'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
